// File: rtl/eth_mac_status_counters.sv
// eth_mac_status_counters
//   Per-event status counters for a MAC, with pending, mask and overflow
//   vectors and a level interrupt. Registers are accessed through a simple
//   one-cycle-latency read port and a write port. Neither port applies
//   backpressure.
//
//   Address map (N = NUM_EVENTS):
//     0..N-1  counter k            RW, optionally cleared on read
//     N       pending vector       W1C
//     N+1     mask vector          RW
//     N+2     overflow vector      W1C (sticky)
//     other   reads 0, writes ignored
//
//   Ports:
//     logic_clk  - clock; all state updates on the rising edge
//     logic_rst  - asynchronous active-high reset
//     event_i    - one-cycle event pulses, one bit per counter
//     rd_v_i     - read request
//     rd_addr_i  - read address
//     rd_v_o     - read data valid, one cycle after rd_v_i
//     rd_data_o  - read data, zero-extended; holds its value between reads
//     wr_v_i     - write request
//     wr_addr_i  - write address
//     wr_data_i  - write data
//     irq_o      - registered OR of (pending & mask)

// One counter lane. A write takes priority over clear-on-read, which in
// turn takes priority over a plain increment.
module eth_mac_status_cnt_lane #(
  parameter int CW            = 32,
  parameter bit SATURATE      = 1'b1,
  parameter bit CLEAR_ON_READ = 1'b1
) (
  input  logic          logic_clk,
  input  logic          logic_rst,
  input  logic          evt,
  input  logic          rd_hit,
  input  logic          wr_hit,
  input  logic [CW-1:0] wr_val,
  output logic [CW-1:0] cnt,
  output logic          ovf_set
);
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    ovf_set = 1'b0;
    if (wr_hit) begin
      cnt_nxt = wr_val;
    end else if (CLEAR_ON_READ && rd_hit) begin
      // The event in the read cycle lands on the freshly zeroed counter.
      cnt_nxt = {{(CW-1){1'b0}}, evt};
    end else if (evt) begin
      if (&cnt) begin
        ovf_set = 1'b1;
        cnt_nxt = SATURATE ? cnt : '0;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge logic_clk or posedge logic_rst) begin
    if (logic_rst) cnt <= '0;
    else           cnt <= cnt_nxt;
  end
endmodule

module eth_mac_status_counters #(
  parameter int NUM_EVENTS    = 10,
  parameter int COUNT_WIDTH   = 32,
  parameter bit SATURATE      = 1'b1,
  parameter bit CLEAR_ON_READ = 1'b1
) (
  input  logic                  logic_clk,
  input  logic                  logic_rst,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic                  rd_v_i,
  input  logic [4:0]            rd_addr_i,
  output logic                  rd_v_o,
  output logic [31:0]           rd_data_o,
  input  logic                  wr_v_i,
  input  logic [4:0]            wr_addr_i,
  input  logic [31:0]           wr_data_i,
  output logic                  irq_o
);
  localparam int          STAGES = 1;
  localparam logic [4:0]  A_PEND = 5'(NUM_EVENTS);
  localparam logic [4:0]  A_MASK = 5'(NUM_EVENTS + 1);
  localparam logic [4:0]  A_OVF  = 5'(NUM_EVENTS + 2);

  typedef struct packed {
    logic       v;
    logic [4:0] addr;
  } rd_req_t;

  typedef struct packed {
    logic        v;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_req_t;

  rd_req_t rd;
  wr_req_t wr;
  assign rd = '{v: rd_v_i, addr: rd_addr_i};
  assign wr = '{v: wr_v_i, addr: wr_addr_i, data: wr_data_i};

  // Upper write-data bits are don't-care for narrow counters/vectors.
  logic unused_wr_bits;
  assign unused_wr_bits = ^wr_data_i;

  logic [NUM_EVENTS-1:0][COUNT_WIDTH-1:0] cnt;
  logic [NUM_EVENTS-1:0] ovf_set;
  logic [NUM_EVENTS-1:0] pending, mask, ovf;
  logic [NUM_EVENTS-1:0] pend_nxt, mask_nxt, ovf_nxt;
  logic [NUM_EVENTS-1:0] pend_clr, ovf_clr;
  logic [31:0]           rd_mux;
  logic                  vld_pipe [STAGES:0];

  for (genvar k = 0; k < NUM_EVENTS; k++) begin : gen_lane
    eth_mac_status_cnt_lane #(
      .CW            (COUNT_WIDTH),
      .SATURATE      (SATURATE),
      .CLEAR_ON_READ (CLEAR_ON_READ)
    ) u_lane (
      .logic_clk (logic_clk),
      .logic_rst (logic_rst),
      .evt       (event_i[k]),
      .rd_hit    (rd.v && rd.addr == 5'(k)),
      .wr_hit    (wr.v && wr.addr == 5'(k)),
      .wr_val    (wr.data[COUNT_WIDTH-1:0]),
      .cnt       (cnt[k]),
      .ovf_set   (ovf_set[k])
    );
  end

  // W1C clears lose to same-cycle sets.
  always_comb begin
    pend_clr = (wr.v && wr.addr == A_PEND) ? wr.data[NUM_EVENTS-1:0] : '0;
    ovf_clr  = (wr.v && wr.addr == A_OVF)  ? wr.data[NUM_EVENTS-1:0] : '0;
    pend_nxt = (pending & ~pend_clr) | event_i;
    ovf_nxt  = (ovf & ~ovf_clr) | ovf_set;
    mask_nxt = (wr.v && wr.addr == A_MASK) ? wr.data[NUM_EVENTS-1:0] : mask;
  end

  // Read mux sees pre-edge state, so same-cycle events/writes are excluded.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_EVENTS; k++)
      if (rd.addr == 5'(k)) rd_mux = 32'(cnt[k]);
    if (rd.addr == A_PEND) rd_mux = 32'(pending);
    if (rd.addr == A_MASK) rd_mux = 32'(mask);
    if (rd.addr == A_OVF)  rd_mux = 32'(ovf);
  end

  assign vld_pipe[0] = rd.v;
  assign rd_v_o      = vld_pipe[STAGES];

  always_ff @(posedge logic_clk or posedge logic_rst) begin
    if (logic_rst) begin
      pending     <= '0;
      mask        <= '0;
      ovf         <= '0;
      irq_o       <= 1'b0;
      vld_pipe[1] <= 1'b0;
      rd_data_o   <= '0;
    end else begin
      pending     <= pend_nxt;
      mask        <= mask_nxt;
      ovf         <= ovf_nxt;
      // Built from next-state values so irq_o follows the event or mask
      // write by a single cycle.
      irq_o       <= |(pend_nxt & mask_nxt);
      vld_pipe[1] <= vld_pipe[0];
      if (rd.v) rd_data_o <= rd_mux;
    end
  end
endmodule

// File: tb/tb_eth_mac_status_counters.sv
module tb_eth_mac_status_counters;
  localparam int N = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  ev;
  logic          rd_v, wr_v;
  logic [4:0]    rd_a, wr_a;
  logic [31:0]   wr_d;

  logic          rdv_m, rdv_s, rdv_w;
  logic [31:0]   rdd_m, rdd_s, rdd_w;
  logic          irq_m, irq_s, irq_w;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  eth_mac_status_counters #(.NUM_EVENTS(N)) dut (
    .logic_clk(clk), .logic_rst(rst), .event_i(ev),
    .rd_v_i(rd_v), .rd_addr_i(rd_a), .rd_v_o(rdv_m), .rd_data_o(rdd_m),
    .wr_v_i(wr_v), .wr_addr_i(wr_a), .wr_data_i(wr_d), .irq_o(irq_m));

  eth_mac_status_counters #(.NUM_EVENTS(N), .COUNT_WIDTH(4), .SATURATE(1'b1)) dut_sat (
    .logic_clk(clk), .logic_rst(rst), .event_i(ev),
    .rd_v_i(rd_v), .rd_addr_i(rd_a), .rd_v_o(rdv_s), .rd_data_o(rdd_s),
    .wr_v_i(wr_v), .wr_addr_i(wr_a), .wr_data_i(wr_d), .irq_o(irq_s));

  eth_mac_status_counters #(.NUM_EVENTS(N), .COUNT_WIDTH(4), .SATURATE(1'b0)) dut_wrap (
    .logic_clk(clk), .logic_rst(rst), .event_i(ev),
    .rd_v_i(rd_v), .rd_addr_i(rd_a), .rd_v_o(rdv_w), .rd_data_o(rdd_w),
    .wr_v_i(wr_v), .wr_addr_i(wr_a), .wr_data_i(wr_d), .irq_o(irq_w));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ev = '0; rd_v = 1'b0; rd_a = '0; wr_v = 1'b0; wr_a = '0; wr_d = '0;
  endtask

  task automatic rd(input logic [4:0] a);
    idle(); rd_v = 1'b1; rd_a = a; tick();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    idle(); wr_v = 1'b1; wr_a = a; wr_d = d; tick();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #1;
    chk("rst_rdv", {31'b0, rdv_m}, 32'd0);
    chk("rst_rdd", rdd_m, 32'd0);
    chk("rst_irq", {31'b0, irq_m}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Five pulses on event 3, read, then re-read after clear-on-read.
    for (int i = 0; i < 5; i++) begin idle(); ev = 10'h008; tick(); end
    rd(5'd3);
    chk("cnt3_rdv", {31'b0, rdv_m}, 32'd1);
    chk("cnt3_5", rdd_m, 32'd5);
    rd(5'd3);
    chk("cnt3_cleared", rdd_m, 32'd0);
    chk("irq_masked", {31'b0, irq_m}, 32'd0);

    // Pending read is non-destructive; rd_data_o holds when idle.
    rd(5'd10);
    chk("pend_rd1", rdd_m, 32'h008);
    rd(5'd10);
    chk("pend_rd2", rdd_m, 32'h008);
    idle(); tick();
    chk("idle_rdv", {31'b0, rdv_m}, 32'd0);
    chk("idle_hold", rdd_m, 32'h008);

    // 17 events on bit 0: 32-bit, 4-bit saturating, 4-bit wrapping.
    for (int i = 0; i < 17; i++) begin idle(); ev = 10'h001; tick(); end
    rd(5'd0);
    chk("c0_main", rdd_m, 32'd17);
    chk("c0_sat", rdd_s, 32'd15);
    chk("c0_wrap", rdd_w, 32'd1);
    rd(5'd12);
    chk("ovf_main", rdd_m, 32'h000);
    chk("ovf_sat", rdd_s, 32'h001);
    chk("ovf_wrap", rdd_w, 32'h001);

    // Clear-on-read with a same-cycle event.
    wr(5'd2, 32'd7);
    idle(); rd_v = 1'b1; rd_a = 5'd2; ev = 10'h004; tick();
    chk("c2_pre", rdd_m, 32'd7);
    rd(5'd2);
    chk("c2_post", rdd_m, 32'd1);

    // Interrupt, mask and W1C with set-wins.
    wr(5'd10, 32'h3FF);
    chk("irq_after_clr", {31'b0, irq_m}, 32'd0);
    wr(5'd11, 32'h004);
    chk("irq_mask_only", {31'b0, irq_m}, 32'd0);
    idle(); ev = 10'h004; tick();
    chk("irq_rise", {31'b0, irq_m}, 32'd1);
    idle(); wr_v = 1'b1; wr_a = 5'd10; wr_d = 32'h004; ev = 10'h004; tick();
    chk("irq_set_wins", {31'b0, irq_m}, 32'd1);
    wr(5'd10, 32'h004);
    chk("irq_fall", {31'b0, irq_m}, 32'd0);
    idle(); ev = 10'h020; tick();
    chk("irq_bit5_masked", {31'b0, irq_m}, 32'd0);
    wr(5'd11, 32'h024);
    chk("irq_mask_on", {31'b0, irq_m}, 32'd1);
    wr(5'd11, 32'h004);
    chk("irq_mask_off", {31'b0, irq_m}, 32'd0);
    rd(5'd11);
    chk("mask_rd", rdd_m, 32'h004);

    // Same-cycle read + write + event on counter 1.
    idle(); rd_v = 1'b1; rd_a = 5'd1; wr_v = 1'b1; wr_a = 5'd1; wr_d = 32'hFFFF;
    ev = 10'h002; tick();
    chk("c1_prewrite", rdd_m, 32'd0);
    rd(5'd1);
    chk("c1_written", rdd_m, 32'h0000FFFF);
    rd(5'd1);
    chk("c1_cleared", rdd_m, 32'd0);

    // Saturation at 32 bits and overflow W1C with set-wins.
    wr(5'd4, 32'hFFFFFFFF);
    idle(); ev = 10'h010; tick();
    rd(5'd12);
    chk("ovf4_set", rdd_m, 32'h010);
    idle(); wr_v = 1'b1; wr_a = 5'd12; wr_d = 32'h010; ev = 10'h010; tick();
    rd(5'd12);
    chk("ovf4_set_wins", rdd_m, 32'h010);
    wr(5'd12, 32'h010);
    rd(5'd12);
    chk("ovf4_cleared", rdd_m, 32'h000);
    rd(5'd4);
    chk("c4_saturated", rdd_m, 32'hFFFFFFFF);

    // Unmapped address.
    wr(5'd20, 32'h123);
    rd(5'd20);
    chk("unmapped", rdd_m, 32'd0);

    // Asynchronous reset in the middle of activity.
    idle(); rd_v = 1'b1; rd_a = 5'd11; ev = 10'h004; tick();
    chk("pre_rst_rdv", {31'b0, rdv_m}, 32'd1);
    chk("pre_rst_irq", {31'b0, irq_m}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_rdv", {31'b0, rdv_m}, 32'd0);
    chk("arst_rdd", rdd_m, 32'd0);
    chk("arst_irq", {31'b0, irq_m}, 32'd0);
    tick(); tick();
    idle();
    rst = 1'b0;
    tick();
    chk("post_rst_rdv", {31'b0, rdv_m}, 32'd0);
    rd(5'd11);
    chk("post_rst_mask", rdd_m, 32'd0);
    rd(5'd2);
    chk("post_rst_c2", rdd_m, 32'd0);
    rd(5'd10);
    chk("post_rst_pend", rdd_m, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
